// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module   : parity_frame_checker
//  Purpose  : Receive-side parity checker for fixed-length frames. Accepts
//             W-bit beats through a valid/ready handshake. It accumulates a
//             running XOR over FRAME_BEATS beats. On the final beat it compares
//             the frame parity against the transmitted parity bit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    W           data bits per beat (>=1)
//    FRAME_BEATS beats per frame (>=1)
//    ODD_MODE    0 = even parity scheme, 1 = odd parity scheme
//    CNT_W       width of the errored-frame counter
//  Ports
//    clk         clock, rising edge
//    rst         asynchronous active-high reset
//    clear       synchronous frame abort (drops the partial frame)
//    in_valid    beat valid
//    in_ready    block can accept a beat
//    in_data     beat data
//    in_par      transmitted parity, sampled on the final beat only
//    par_run     running XOR of accepted bits in the current frame
//    frame_done  one-cycle pulse, frame result valid
//    frame_par   computed parity of the last completed frame (held)
//    par_err     1 = parity mismatch, qualified by frame_done
//    err_count   saturating errored-frame count (PARITY_ERR_CNT_EN only)
//  Build option
//    PARITY_ERR_CNT_EN  adds the err_count port and its counter
// ============================================================================
module parity_frame_checker #(
    parameter int W           = 8,
    parameter int FRAME_BEATS = 4,
    parameter int ODD_MODE    = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_par,
    output logic             par_run,
    output logic             frame_done,
    output logic             frame_par,
    output logic             par_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam int c_CNT_BITS = $clog2(FRAME_BEATS + 1);
    localparam logic [c_CNT_BITS-1:0] c_LAST = c_CNT_BITS'(FRAME_BEATS);
    localparam logic c_ODD = (ODD_MODE != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic                  r_par_run;
    logic                  r_in_ready;
    logic                  r_frame_done;
    logic                  r_frame_par;
    logic                  r_par_err;

    logic                  w_accept;
    logic                  w_par_next;
    logic                  w_frame_par;
    logic [c_CNT_BITS-1:0] w_cnt_inc;

    assign w_accept    = in_valid & r_in_ready;
    assign w_par_next  = r_par_run ^ (^in_data);
    assign w_frame_par = w_par_next ^ c_ODD;
    assign w_cnt_inc   = r_cnt + 1'b1;

    // in_ready is registered: it is low during reset and drops for the
    // single REPORT cycle, so a producer sees a clean one-cycle stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_par_run    <= 1'b0;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_par  <= 1'b0;
            r_par_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (clear) begin
                        // Abort wins over a beat presented in the same cycle.
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_par_run  <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else if (w_accept) begin
                        r_par_run <= w_par_next;
                        r_cnt     <= w_cnt_inc;
                        if (w_cnt_inc == c_LAST) begin
                            r_state      <= S_REPORT;
                            r_in_ready   <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_frame_par  <= w_frame_par;
                            r_par_err    <= (in_par != w_frame_par);
                        end else begin
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_REPORT: begin
                    // Report always completes; clear has nothing extra to do
                    // because the frame state is zeroed here anyway.
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_par_run  <= 1'b0;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_par_run  <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign par_run    = r_par_run;
    assign frame_done = r_frame_done;
    assign frame_par  = r_frame_par;
    // The mismatch flag is held internally but only shown with frame_done.
    assign par_err    = r_frame_done & r_par_err;

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_frame_done && r_par_err && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire
